origami_mem_arbiter: RTL and testbench

ORIGAMI_MEM_ARBITER -- requirements
Module: origami_mem_arbiter

---
 rtl/origami_mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_origami_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/origami_mem_arbiter.sv
// origami_mem_arbiter
// Arbitrates a fetch requester (read-only) and a load/store requester onto a
// single shared memory port, one transaction at a time.
//
// Ports
//   clock_i, reset_ni            : clock, asynchronous active-low reset
//   if_req_i, if_addr_i          : fetch request
//   if_gnt_o, if_rvalid_o,
//   if_rdata_o, if_err_o         : fetch grant / response
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i, d_be_i            : load/store request
//   d_gnt_o, d_rvalid_o,
//   d_rdata_o, d_err_o           : load/store grant / response
//   mem_req_o .. mem_be_o        : shared memory request (from latched copies)
//   mem_ack_i, mem_rdata_i       : memory completion
//   arb_state_o                  : FSM state (IDLE=0 BUSY_IF=1 BUSY_D=2 DONE=3)
//
// Data wins contention unless the fetch side has watched STARVE_LIMIT data
// grants go by while it was asking. A transaction that sees no mem_ack for
// TIMEOUT busy cycles is aborted and answered with err=1, rdata=0.
module origami_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    // fetch requester
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    // load/store requester
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_be_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,
    // shared memory port
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    // debug
    output logic [1:0]  arb_state_o
);

    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Attributes of the transaction in flight, captured at grant.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mreq_t;

    state_e        state_q, state_d;
    mreq_t         lat_q, lat_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic          if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic          if_err_q, if_err_d, d_err_q, d_err_d;
    logic [31:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic          busy;
    logic [31:0]   rd_cap;

    assign busy   = (state_q == BUSY_IF) || (state_q == BUSY_D);
    // Writes return zero rather than whatever the bus happens to carry.
    assign rd_cap = lat_q.we ? 32'h0 : mem_rdata_i;

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_err_d    = 1'b0;
        d_err_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (!if_req_i) starve_d = '0;
                if (if_req_i || d_req_i) begin
                    wait_d = '0;
                    if (if_req_i && (!d_req_i || starve_q == STARVE_MAX)) begin
                        state_d     = BUSY_IF;
                        lat_d.we    = 1'b0;
                        lat_d.addr  = if_addr_i;
                        lat_d.wdata = 32'h0;
                        lat_d.be    = 4'hF;
                        if_gnt_d    = 1'b1;
                        starve_d    = '0;
                    end else begin
                        state_d     = BUSY_D;
                        lat_d.we    = d_we_i;
                        lat_d.addr  = d_addr_i;
                        lat_d.wdata = d_wdata_i;
                        lat_d.be    = d_be_i;
                        d_gnt_d     = 1'b1;
                        // Only grants that made fetch wait count toward starvation.
                        if (if_req_i && starve_q != STARVE_MAX)
                            starve_d = starve_q + SW'(1);
                    end
                end
            end
            BUSY_IF, BUSY_D: begin
                // An ack on the final allowed cycle still completes normally.
                if (mem_ack_i) begin
                    state_d = DONE;
                    if (state_q == BUSY_D) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = rd_cap;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = rd_cap;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                    if (wait_q == WAIT_LAST) begin
                        state_d = DONE;
                        if (state_q == BUSY_D) begin
                            d_rvalid_d = 1'b1;
                            d_err_d    = 1'b1;
                            d_rdata_d  = 32'h0;
                        end else begin
                            if_rvalid_d = 1'b1;
                            if_err_d    = 1'b1;
                            if_rdata_d  = 32'h0;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            starve_q    <= '0;
            wait_q      <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_err_q    <= if_err_d;
            d_err_q     <= d_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_gnt_o    = if_gnt_q;
    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_err_o    = if_err_q;
    assign d_gnt_o     = d_gnt_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_err_o     = d_err_q;

    // Request/we/be are qualified by the busy state so they fall with reset
    // or the abort without waiting for a clock edge.
    assign mem_req_o   = busy;
    assign mem_we_o    = busy & lat_q.we;
    assign mem_be_o    = busy ? lat_q.be : 4'h0;
    assign mem_addr_o  = lat_q.addr;
    assign mem_wdata_o = lat_q.wdata;
    assign arb_state_o = state_q;

endmodule

// File: tb/tb_origami_mem_arbiter.sv
module tb_origami_mem_arbiter;

    localparam int LIMIT = 3;
    localparam int TMO   = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 0, d_req = 0, d_we = 0, mem_ack = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [3:0]  d_be = 0;
    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
    logic        mem_req, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [1:0]  arb_state;

    int tests_run = 0;
    int tests_failed = 0;

    // observations from the last transaction
    logic        o_gnt_if, o_gnt_d, o_we, o_done, o_stable, o_mreq_done, o_err_if, o_err_d;
    logic [1:0]  o_state1, o_state_after;
    logic [31:0] o_addr, o_wdata, o_rd_if, o_rd_d;
    logic [3:0]  o_be;
    int          o_busy, o_we_cnt, o_rv_if, o_rv_d;

    origami_mem_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
        .clock_i(clk), .reset_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_be_i(d_be), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .d_err_o(d_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_rdata), .arb_state_o(arb_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one request from IDLE and records what the DUT does until it is
    // back in IDLE. ack_cyc = busy cycle (1-based) carrying mem_ack, 0 = never.
    task automatic txn(input bit ifr, input bit dr, input logic [31:0] ia,
                       input bit dwe, input logic [31:0] da, input logic [31:0] dwd,
                       input logic [3:0] dbe, input int ack_cyc, input logic [31:0] ack_rd);
        int k;
        if_req = ifr; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da;
        d_wdata = dwd; d_be = dbe;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        @(negedge clk);
        o_gnt_if = if_gnt; o_gnt_d = d_gnt; o_state1 = arb_state;
        o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we; o_be = mem_be;
        o_stable = 1; o_busy = 0; o_we_cnt = 0; o_rv_if = 0; o_rv_d = 0;
        // requester drops and scrambles its attributes once granted
        if_req = 0; d_req = 0; if_addr = $urandom; d_addr = $urandom;
        d_wdata = $urandom; d_be = 4'($urandom); d_we = 1'($urandom);
        k = 1;
        while (arb_state != 2'd3 && k <= TMO + 2) begin
            if (mem_req === 1'b1) o_busy++;
            if (mem_we === 1'b1) o_we_cnt++;
            if (mem_addr !== o_addr || mem_wdata !== o_wdata || mem_be !== o_be || mem_we !== o_we)
                o_stable = 0;
            if (if_rvalid === 1'b1) o_rv_if++;
            if (d_rvalid === 1'b1) o_rv_d++;
            mem_ack = (k == ack_cyc);
            mem_rdata = (k == ack_cyc) ? ack_rd : $urandom;
            @(negedge clk);
            k++;
        end
        o_done = (arb_state == 2'd3);
        o_mreq_done = mem_req;
        if (if_rvalid === 1'b1) o_rv_if++;
        if (d_rvalid === 1'b1) o_rv_d++;
        o_err_if = if_err; o_err_d = d_err; o_rd_if = if_rdata; o_rd_d = d_rdata;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        @(negedge clk);
        o_state_after = arb_state;
        if (if_rvalid === 1'b1) o_rv_if++;
        if (d_rvalid === 1'b1) o_rv_d++;
        mem_ack = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(negedge clk); @(negedge clk);
        tests_run++; if (arb_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d exp 0", arb_state); end
        tests_run++; if ({mem_req, mem_we, mem_be} !== 6'd0) begin tests_failed++; $display("FAIL reset_mem_ctl: got req=%b we=%b be=%h exp 0", mem_req, mem_we, mem_be); end
        tests_run++; if ({mem_addr, mem_wdata} !== 64'd0) begin tests_failed++; $display("FAIL reset_mem_data: got addr=%h wdata=%h exp 0", mem_addr, mem_wdata); end
        tests_run++; if ({if_rdata, d_rdata} !== 64'd0) begin tests_failed++; $display("FAIL reset_rdata: got if=%h d=%h exp 0", if_rdata, d_rdata); end
        tests_run++; if ({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err} !== 6'd0) begin tests_failed++; $display("FAIL reset_handshake: got %b exp 000000", {if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err}); end
        rst_n = 1;
    endtask

    task automatic test_fetch_basic();
        txn(1, 0, 32'h100, 0, 0, 0, 0, 1, 32'h00500093);
        tests_run++; if ({o_gnt_if, o_gnt_d} !== 2'b10) begin tests_failed++; $display("FAIL fetch_gnt: got if=%b d=%b exp 1/0", o_gnt_if, o_gnt_d); end
        tests_run++; if (o_state1 !== 2'd1) begin tests_failed++; $display("FAIL fetch_state: got %0d exp 1", o_state1); end
        tests_run++; if ({o_addr, o_we, o_be} !== {32'h100, 1'b0, 4'hF}) begin tests_failed++; $display("FAIL fetch_attr: got addr=%h we=%b be=%h exp 100/0/f", o_addr, o_we, o_be); end
        tests_run++; if (o_busy !== 1 || !o_done) begin tests_failed++; $display("FAIL fetch_latency: got busy=%0d done=%b exp 1/1", o_busy, o_done); end
        tests_run++; if (o_rv_if !== 1 || o_rv_d !== 0) begin tests_failed++; $display("FAIL fetch_rvalid: got if=%0d d=%0d exp 1/0", o_rv_if, o_rv_d); end
        tests_run++; if (o_rd_if !== 32'h00500093 || o_err_if !== 1'b0) begin tests_failed++; $display("FAIL fetch_rdata: got %h err=%b exp 00500093/0", o_rd_if, o_err_if); end
        tests_run++; if (o_state_after !== 2'd0) begin tests_failed++; $display("FAIL fetch_back_idle: got %0d exp 0", o_state_after); end
    endtask

    task automatic test_starvation();
        logic [7:0] got, exp_order;
        got = 0;
        exp_order = 8'b1000_1000; // bit i = fetch won grant i: D,D,D,IF,D,D,D,IF
        for (int i = 0; i < 8; i++) begin
            txn(1, 1, 32'h1000 + 32'(i * 4), 0, 32'h2000 + 32'(i * 4), 0, 4'hF, 1, 32'hA000 + 32'(i));
            got[i] = o_gnt_if;
            tests_run++;
            if (o_gnt_if === o_gnt_d) begin tests_failed++; $display("FAIL starve_onehot[%0d]: got if=%b d=%b exp exactly one", i, o_gnt_if, o_gnt_d); end
        end
        tests_run++; if (got !== exp_order) begin tests_failed++; $display("FAIL starve_order: got %b exp %b", got, exp_order); end
        tests_run++; if (o_rd_if !== 32'hA007) begin tests_failed++; $display("FAIL starve_last_rdata: got %h exp a007", o_rd_if); end
    endtask

    task automatic test_write_wait();
        txn(0, 1, 0, 1, 32'h200, 32'hDEADBEEF, 4'b0011, 5, 32'h5555AAAA);
        tests_run++; if ({o_gnt_d, o_gnt_if} !== 2'b10) begin tests_failed++; $display("FAIL wr_gnt: got d=%b if=%b exp 1/0", o_gnt_d, o_gnt_if); end
        tests_run++; if ({o_addr, o_wdata, o_be} !== {32'h200, 32'hDEADBEEF, 4'b0011}) begin tests_failed++; $display("FAIL wr_attr: got %h %h %b", o_addr, o_wdata, o_be); end
        tests_run++; if (o_busy !== 5 || o_we_cnt !== 5 || !o_stable) begin tests_failed++; $display("FAIL wr_hold: got busy=%0d we=%0d stable=%b exp 5/5/1", o_busy, o_we_cnt, o_stable); end
        tests_run++; if (o_rv_d !== 1 || o_rv_if !== 0) begin tests_failed++; $display("FAIL wr_rvalid: got d=%0d if=%0d exp 1/0", o_rv_d, o_rv_if); end
        tests_run++; if (o_rd_d !== 32'h0 || o_err_d !== 1'b0) begin tests_failed++; $display("FAIL wr_rdata: got %h err=%b exp 0/0", o_rd_d, o_err_d); end
        tests_run++; if (o_rd_if !== 32'hA007) begin tests_failed++; $display("FAIL wr_if_hold: got %h exp a007", o_rd_if); end
    endtask

    task automatic test_timeout();
        txn(1, 0, 32'h300, 0, 0, 0, 0, 0, 0);
        tests_run++; if (o_busy !== TMO || !o_done) begin tests_failed++; $display("FAIL tmo_busy: got %0d done=%b exp %0d/1", o_busy, o_done, TMO); end
        tests_run++; if (o_mreq_done !== 1'b0) begin tests_failed++; $display("FAIL tmo_mreq_drop: got %b exp 0", o_mreq_done); end
        tests_run++; if (o_rv_if !== 1 || o_err_if !== 1'b1 || o_rd_if !== 32'h0) begin tests_failed++; $display("FAIL tmo_resp: got rv=%0d err=%b rd=%h exp 1/1/0", o_rv_if, o_err_if, o_rd_if); end
        tests_run++; if (o_rv_d !== 0 || o_err_d !== 1'b0) begin tests_failed++; $display("FAIL tmo_nonowner: got rv=%0d err=%b exp 0/0", o_rv_d, o_err_d); end
    endtask

    task automatic test_ack_at_timeout();
        txn(1, 0, 32'h304, 0, 0, 0, 0, TMO, 32'h12345678);
        tests_run++; if (o_busy !== TMO) begin tests_failed++; $display("FAIL acktmo_busy: got %0d exp %0d", o_busy, TMO); end
        tests_run++; if (o_rv_if !== 1 || o_err_if !== 1'b0 || o_rd_if !== 32'h12345678) begin tests_failed++; $display("FAIL acktmo_resp: got rv=%0d err=%b rd=%h exp 1/0/12345678", o_rv_if, o_err_if, o_rd_if); end
    endtask

    task automatic test_reset_mid();
        int rv;
        rv = 0;
        d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h77; d_be = 4'hF;
        @(negedge clk);
        d_req = 0;
        tests_run++; if (arb_state !== 2'd2) begin tests_failed++; $display("FAIL rstmid_busy: got %0d exp 2", arb_state); end
        @(negedge clk); @(negedge clk);
        #2 rst_n = 0;
        #1;
        tests_run++; if (mem_req !== 1'b0 || arb_state !== 2'd0 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL rstmid_async: got req=%b state=%0d we=%b exp 0/0/0", mem_req, arb_state, mem_we); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (d_rvalid === 1'b1) rv++;
        end
        rst_n = 1;
        txn(0, 1, 0, 0, 32'h404, 0, 4'hF, 2, 32'hCAFE0001);
        rv += o_rv_d;
        tests_run++; if (o_gnt_d !== 1'b1) begin tests_failed++; $display("FAIL rstmid_regrant: got %b exp 1", o_gnt_d); end
        tests_run++; if (rv !== 1 || o_rd_d !== 32'hCAFE0001) begin tests_failed++; $display("FAIL rstmid_rvalid: got cnt=%0d rd=%h exp 1/cafe0001", rv, o_rd_d); end
    endtask

    // Randomized traffic against a transaction-level model of the arbiter rules.
    task automatic test_random();
        int starve, ack_cyc, busy_e;
        logic [31:0] m_if_rd, m_d_rd, ia, da, dwd, ack_rd, rd_e;
        logic [3:0] dbe;
        bit ifr, dr, dwe, win_d, timed;
        starve = 0; m_if_rd = 32'h0; m_d_rd = 32'hCAFE0001;
        for (int it = 0; it < 60; it++) begin
            ifr = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin ifr = 1; dr = 1; end
            if (!ifr && !dr) begin
                if_req = 0; d_req = 0; mem_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
                mem_ack = 0;
                starve = 0;
                tests_run++;
                if ({if_gnt, d_gnt, mem_req, arb_state} !== 5'd0) begin tests_failed++; $display("FAIL rnd_idle[%0d]: got gnt=%b%b req=%b st=%0d exp all 0", it, if_gnt, d_gnt, mem_req, arb_state); end
                continue;
            end
            ia = $urandom; da = $urandom; dwd = $urandom; dbe = 4'($urandom); dwe = 1'($urandom);
            ack_rd = $urandom;
            ack_cyc = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 4) : $urandom_range(0, TMO + 2);
            win_d = dr && !(ifr && starve == LIMIT);
            if (!win_d) starve = 0;
            else if (ifr) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
            else starve = 0;
            timed = (ack_cyc == 0 || ack_cyc > TMO);
            busy_e = timed ? TMO : ack_cyc;
            rd_e = (timed || (win_d && dwe)) ? 32'h0 : ack_rd;
            if (win_d) m_d_rd = rd_e; else m_if_rd = rd_e;
            txn(ifr, dr, ia, dwe, da, dwd, dbe, ack_cyc, ack_rd);
            tests_run++;
            if (o_gnt_d !== win_d || o_gnt_if !== !win_d) begin tests_failed++; $display("FAIL rnd_gnt[%0d]: got if=%b d=%b exp d=%b", it, o_gnt_if, o_gnt_d, win_d); end
            tests_run++;
            if (o_addr !== (win_d ? da : ia) || o_we !== (win_d && dwe) || o_be !== (win_d ? dbe : 4'hF) || (win_d && o_wdata !== dwd) || !o_stable)
                begin tests_failed++; $display("FAIL rnd_attr[%0d]: got a=%h we=%b be=%h wd=%h st=%b", it, o_addr, o_we, o_be, o_wdata, o_stable); end
            tests_run++;
            if (o_busy !== busy_e || o_we_cnt !== ((win_d && dwe) ? busy_e : 0) || !o_done || o_mreq_done !== 1'b0)
                begin tests_failed++; $display("FAIL rnd_timing[%0d]: got busy=%0d we=%0d done=%b exp busy=%0d", it, o_busy, o_we_cnt, o_done, busy_e); end
            tests_run++;
            if (o_rv_d !== int'(win_d) || o_rv_if !== int'(!win_d) || o_err_d !== (win_d && timed) || o_err_if !== (!win_d && timed))
                begin tests_failed++; $display("FAIL rnd_resp[%0d]: got rv=%0d/%0d err=%b/%b exp timed=%b d=%b", it, o_rv_if, o_rv_d, o_err_if, o_err_d, timed, win_d); end
            tests_run++;
            if (o_rd_if !== m_if_rd || o_rd_d !== m_d_rd || o_state_after !== 2'd0)
                begin tests_failed++; $display("FAIL rnd_rdata[%0d]: got %h/%h st=%0d exp %h/%h/0", it, o_rd_if, o_rd_d, o_state_after, m_if_rd, m_d_rd); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_starvation();
        test_write_wait();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
